// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Resolves BITS_PER_CYCLE multiplier or quotient bits per RUN cycle.
// Signed ops run on magnitudes, and the sign is fixed up in the FIN cycle.
// HI/LO change only as a whole: on the FIN edge or on an MTHI/MTLO accept.
module muldiv_unit #(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int B     = BITS_PER_CYCLE;
    localparam int N     = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    // Handshake: start_i is a request qualified by state==IDLE and flush_i==0;
    // busy_o (registered) is the "not ready" back-pressure for the hazard unit;
    // done_o is a single-cycle pulse in the cycle after HI/LO were written.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // state is the observation point for external checkers
    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_step;
    logic [DATA_W-1:0]   opb;
    logic                is_div;
    logic                neg_lo;
    logic                neg_hi;
    logic                start_md;
    logic                start_mt;
    logic                commit;

    logic                sign_a;
    logic                sign_b;
    logic                rt_zero;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;

    logic [DATA_W+B-1:0]   mul_sum;
    logic [2*DATA_W+B-1:0] mul_cat;
    logic [DATA_W:0]       div_trial;
    logic [DATA_W-1:0]     div_rem;
    logic [DATA_W-1:0]     div_quo;

    logic [2*DATA_W-1:0] prod_fin;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;

    // Next-state decode: accept in IDLE, count through RUN, commit in FIN unless flushed
    always_comb begin
        state_next = state;
        start_md   = 1'b0;
        start_mt   = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !flush_i) begin
                    if (!op_i[2]) begin
                        start_md   = 1'b1;
                        state_next = RUN;
                    end else if (!op_i[1]) begin
                        start_mt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else if (cnt == CNT_W'(N - 1)) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
                commit     = !flush_i;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered busy/done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_next;
            busy_o <= (state_next != IDLE);
            done_o <= commit || start_mt;
        end
    end

    // Operand magnitudes; the signed ops (MULT, DIV) have op_i[0]==0
    always_comb begin
        sign_a  = !op_i[0] && rs_i[DATA_W-1];
        sign_b  = !op_i[0] && rt_i[DATA_W-1];
        rt_zero = (rt_i == '0);
        mag_a   = sign_a ? -rs_i : rs_i;
        mag_b   = sign_b ? -rt_i : rt_i;
    end

    // One RUN step: radix-2^B shift-add, or B restoring-division bit steps
    always_comb begin
        mul_sum = {{B{1'b0}}, acc[2*DATA_W-1:DATA_W]};
        for (int j = 0; j < B; j++) begin
            if (acc[j]) begin
                mul_sum = mul_sum + ({{B{1'b0}}, opb} << j);
            end
        end
        mul_cat = {mul_sum, acc[DATA_W-1:0]} >> B;

        div_rem   = acc[2*DATA_W-1:DATA_W];
        div_quo   = acc[DATA_W-1:0];
        div_trial = '0;
        for (int j = 0; j < B; j++) begin
            div_trial = {div_rem, div_quo[DATA_W-1]};
            if (div_trial >= {1'b0, opb}) begin
                div_trial = div_trial - {1'b0, opb};
                div_quo   = {div_quo[DATA_W-2:0], 1'b1};
            end else begin
                div_quo   = {div_quo[DATA_W-2:0], 1'b0};
            end
            div_rem = div_trial[DATA_W-1:0];
        end

        acc_step = is_div ? {div_rem, div_quo} : mul_cat[2*DATA_W-1:0];
    end

    // Datapath: latch operands on accept, iterate in RUN.
    // A zero divisor keeps the raw dividend and skips sign fix-up, so the
    // natural all-ones quotient and untouched dividend fall out as LO/HI.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else if (start_md) begin
            cnt    <= '0;
            is_div <= op_i[1];
            if (op_i[1]) begin
                opb    <= mag_b;
                acc    <= {{DATA_W{1'b0}}, (rt_zero ? rs_i : mag_a)};
                neg_lo <= !rt_zero && (sign_a ^ sign_b);
                neg_hi <= !rt_zero && sign_a;
            end else begin
                opb    <= mag_a;
                acc    <= {{DATA_W{1'b0}}, mag_b};
                neg_lo <= sign_a ^ sign_b;
                neg_hi <= sign_a ^ sign_b;
            end
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_step;
        end
    end

    // FIN sign correction: full-width negate for products, per-half for divide
    always_comb begin
        prod_fin = neg_lo ? -acc : acc;
        res_hi   = prod_fin[2*DATA_W-1:DATA_W];
        res_lo   = prod_fin[DATA_W-1:0];
        if (is_div) begin
            res_lo = neg_lo ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
            res_hi = neg_hi ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
        end
    end

    // Architectural HI/LO: whole-result commit, or a single MTHI/MTLO write
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (commit) begin
            hi_o <= res_hi;
            lo_o <= res_lo;
        end else if (start_mt) begin
            if (!op_i[0]) begin
                hi_o <= rs_i;
            end else begin
                lo_o <= rs_i;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: two instances (1 and 4 bits per cycle)
// share operand/flush/reset wiring and have separate start strobes.
module tb_muldiv_unit;
    localparam int W  = 32;
    localparam int N1 = 32;
    localparam int N4 = 8;
    localparam int NV = 13;

    logic         clk = 1'b0;
    logic         rst;
    logic         start1;
    logic         start4;
    logic         flush;
    logic [2:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic         busy1, done1, busy4, done4;
    logic [W-1:0] hi1, lo1, hi4, lo4;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp1_q[$];
    logic [2*W-1:0] exp4_q[$];
    logic [W-1:0]   m_hi[2];
    logic [W-1:0]   m_lo[2];

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;
    vec_t vecs[NV];

    muldiv_unit #(.DATA_W(W), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .op_i(op), .rs_i(rs), .rt_i(rt),
        .flush_i(flush), .busy_o(busy1), .done_o(done1), .hi_o(hi1), .lo_o(lo1)
    );

    muldiv_unit #(.DATA_W(W), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .op_i(op), .rs_i(rs), .rt_i(rt),
        .flush_i(flush), .busy_o(busy4), .done_o(done4), .hi_o(hi4), .lo_o(lo4)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the MIPS HI/LO rules
    function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] h,
                                          input logic [W-1:0] l);
        longint     sa;
        longint     sb;
        longint     q;
        longint     r;
        logic [63:0] q64;
        logic [63:0] r64;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2, 3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (o == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    q64 = q;
                    r64 = r;
                    return {r64[31:0], q64[31:0]};
                end
                return {a % b, a / b};
            end
            3'd4: return {a, l};
            3'd5: return {h, a};
            default: return {h, l};
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && done1) begin
            check("dut1 busy during done", 64'(busy1), 64'(0));
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected done_o: got 1 expected 0");
            end else begin
                check("dut1 hi/lo", {hi1, lo1}, exp1_q.pop_front());
            end
        end
        if (!rst && done4) begin
            check("dut4 busy during done", 64'(busy4), 64'(0));
            if (exp4_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4 unexpected done_o: got 1 expected 0");
            end else begin
                check("dut4 hi/lo", {hi4, lo4}, exp4_q.pop_front());
            end
        end
    end

    // Waits (from a negedge) for done on one instance; returns at a negedge
    task automatic wait_done(input int w, input int limit, output int edges,
                             output int busy_cnt, output bit seen);
        edges    = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        forever begin
            @(negedge clk);
            if ((w == 0) ? busy1 : busy4) busy_cnt++;
            if ((w == 0) ? done1 : done4) begin
                seen = 1'b1;
                break;
            end
            if (edges >= limit) break;
            @(posedge clk);
            edges++;
        end
    endtask

    // Driver: issue one op at the current negedge, check latency and busy length
    task automatic run_op(input int w, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp);
        int edges;
        int busy_cnt;
        bit seen;
        int n;
        n  = (w == 0) ? N1 : N4;
        op = o;
        rs = a;
        rt = b;
        if (w == 0) start1 = 1'b1;
        else        start4 = 1'b1;
        if (o < 3'd6) begin
            if (w == 0) exp1_q.push_back(exp);
            else        exp4_q.push_back(exp);
        end
        m_hi[w] = exp[63:32];
        m_lo[w] = exp[31:0];
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        rs = $urandom;
        rt = $urandom;
        wait_done(w, (o >= 3'd6) ? 2 : n + 4, edges, busy_cnt, seen);
        if (o >= 3'd6) begin
            check("noop done", 64'(seen), 64'(0));
            check("noop busy cycles", 64'(busy_cnt), 64'(0));
            check("noop hold", (w == 0) ? {hi1, lo1} : {hi4, lo4}, exp);
        end else if (!seen) begin
            checks++;
            errors++;
            $display("FAIL dut%0d op %0d done timeout: got none expected pulse", (w == 0) ? 1 : 4, o);
        end else if (o >= 3'd4) begin
            check("mt latency", 64'(edges), 64'(0));
            check("mt busy cycles", 64'(busy_cnt), 64'(0));
        end else begin
            check("md latency", 64'(edges), 64'(n + 1));
            check("md busy cycles", 64'(busy_cnt), 64'(n + 1));
        end
    endtask

    initial begin
        int edges;
        int busy_cnt;
        bit seen;
        logic [2:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{3'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
        vecs[5]  = '{3'd4, 32'h0000_0055, 32'h0000_0009, 32'h0000_0055, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'h0000_A5A5, 32'h0000_0000, 32'h0000_0055, 32'h0000_A5A5};
        vecs[7]  = '{3'd2, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF};
        vecs[8]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[9]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[10] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[11] = '{3'd7, 32'h0000_0123, 32'h0000_0456, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[12] = '{3'd1, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000};

        // reset
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0; flush = 1'b0;
        op = 3'd6; rs = '0; rt = '0;
        for (int i = 0; i < 2; i++) begin
            m_hi[i] = '0;
            m_lo[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset hi/lo dut1", {hi1, lo1}, 64'h0);
        check("reset hi/lo dut4", {hi4, lo4}, 64'h0);
        check("reset busy/done", {62'd0, busy1 | busy4, done1 | done4}, 64'h0);

        // table-driven vectors, back-to-back, on both instances
        for (int i = 0; i < NV; i++) begin
            for (int w = 0; w < 2; w++) begin
                run_op(w, vecs[i].op, vecs[i].rs, vecs[i].rt, {vecs[i].hi, vecs[i].lo});
            end
        end

        // randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            for (int w = 0; w < 2; w++) begin
                run_op(w, o, a, b, model(o, a, b, m_hi[w], m_lo[w]));
            end
        end

        // flush at RUN cycle 10: no commit, no done
        op = 3'd0; rs = 32'h1234_5678; rt = 32'hFFFF_0001; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("busy before flush", 64'(busy1), 64'(1));
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("busy after run flush", 64'(busy1), 64'(0));
        repeat (N1 + 4) @(negedge clk);
        check("hold after run flush", {hi1, lo1}, {m_hi[0], m_lo[0]});

        // flush in the FIN cycle: commit is suppressed
        op = 3'd3; rs = 32'h0000_0100; rt = 32'h0000_0003; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (N1) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("busy after fin flush", 64'(busy1), 64'(0));
        repeat (N1 + 4) @(negedge clk);
        check("hold after fin flush", {hi1, lo1}, {m_hi[0], m_lo[0]});

        // flush together with start in IDLE: both MTHI and DIV are dropped
        op = 3'd4; rs = 32'hDEAD_BEEF; start1 = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 op = 3'd2; rt = 32'h5;
        @(negedge clk);
        check("flush+mthi hold", {hi1, lo1}, {m_hi[0], m_lo[0]});
        @(posedge clk);
        #1 start1 = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush+div busy", 64'(busy1), 64'(0));

        // start while busy is ignored; result belongs to the first op
        a = 32'hFFFF_8000; b = 32'h0000_0077;
        op = 3'd2; rs = a; rt = b; start1 = 1'b1;
        exp1_q.push_back(model(3'd2, a, b, m_hi[0], m_lo[0]));
        {m_hi[0], m_lo[0]} = model(3'd2, a, b, m_hi[0], m_lo[0]);
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        op = 3'd1; rs = 32'h3; rt = 32'h4; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        wait_done(0, N1 + 4, edges, busy_cnt, seen);
        check("busy-start done seen", 64'(seen), 64'(1));
        check("busy-start latency", 64'(edges), 64'(N1 + 1 - 4));
        repeat (N1 + 4) @(negedge clk);

        // reset in the middle of a divide: everything clears, no done
        op = 3'd2; rs = 32'h7654_3210; rt = 32'h0000_0013; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_hi[i] = '0;
            m_lo[i] = '0;
        end
        @(negedge clk);
        check("mid-op reset hi/lo", {hi1, lo1}, 64'h0);
        check("mid-op reset busy/done", {62'd0, busy1, done1}, 64'h0);
        repeat (N1 + 4) @(negedge clk);

        // the unit still works after the reset
        run_op(0, 3'd0, 32'hFFFF_FFF0, 32'h0000_0010, model(3'd0, 32'hFFFF_FFF0, 32'h10, m_hi[0], m_lo[0]));
        repeat (2) @(negedge clk);

        check("scoreboard drained", 64'(exp1_q.size() + exp4_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
